sfq_xor_monitor: RTL
====================

Name: sfq_xor_monitor

Overview:
- Receive-side checker for the toggle-encoded SFQ pulse interface used by the clocked XOR cell benches.
- Each toggle of a, b, sfq clk or out is one SFQ pulse.
- Decodes the toggles into pulse events, runs the clocked-XOR state machine, and predicts each output pulse.
- Checks the DUT's out toggles against the predictions within a window; reports errors and counts. Sits in the bench beside the DUT and samples on a fast system clock.

Parameters:
- WINDOW, 8, number of clk cycles after a predicted output pulse during which the out toggle must arrive (1..255).
- CNT_W, 8, width of the out_cnt and err_cnt counters.

Ports:
- clk  input  1  system sample clock; must be faster than any pulse spacing.
- rst  input  1  asynchronous, active-high reset.
- a_tgl  input  1  toggle-encoded input pulse A.
- b_tgl  input  1  toggle-encoded input pulse B.
- sclk_tgl  input  1  toggle-encoded SFQ clock pulse.
- out_tgl  input  1  toggle-encoded DUT output.
- exp_pulse  output  1  one-cycle strobe: an output pulse is predicted.
- err_pulse  output  1  one-cycle strobe: an error is detected.
- err_code  output  2  last error: 0 none, 1 missing, 2 spurious, 3 overrun.
- xor_state  output  2  model state: 0 IDLE, 1 ONE_A, 2 ONE_B, 3 BOTH.
- out_cnt  output  CNT_W  correctly matched output pulses (saturating).
- err_cnt  output  CNT_W  total errors (saturating).

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0; xor_state is IDLE; sync flops are 0; pending is cleared.
  - After release, events are masked for 3 clk cycles while the sync flops settle.
- Decode:
  - Each input passes through a 2-flop synchroniser plus one history flop.
  - event = sync2 XOR hist, a one-cycle strobe.
  - Latency from input toggle to event is 3 clk cycles. Both toggle directions count.
- Order of operations when events share a cycle:
  1. out_ev is matched against the existing pending expectation.
  2. sclk_ev evaluates and clears the model.
  3. a_ev / b_ev update the post-clock state.
- State transitions:
  - a_ev: IDLE to ONE_A; ONE_A stays ONE_A (pulses merge); ONE_B to BOTH; BOTH stays BOTH.
  - b_ev: symmetric to a_ev.
  - a_ev and b_ev together: IDLE to BOTH; ONE_x to BOTH.
- On sclk_ev:
  - expected = (state is ONE_A or ONE_B). The state goes to IDLE, then same-cycle data events apply.
  - If expected: exp_pulse = 1 for that cycle. If pending is already active, raise overrun (code 3) first. Then set pending and load the window counter with WINDOW.
  - If not expected and pending is active: raise overrun, clear pending.
- Pending:
  - The counter decrements each cycle. out_ev while pending counts as a match: out_cnt++, pending cleared.
  - Counter at 1 with no out_ev: missing (code 1), pending cleared at the end of that cycle.
  - out_ev with no pending: spurious (code 2).
- Error reporting:
  - err_pulse lasts 1 cycle; err_code updates on that same cycle and holds until the next error.
  - At most one err_cnt increment per cycle. Priority: overrun, then missing, then spurious. err_code shows the winner.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-operation: all state and counters cleared immediately; no error flagged.

Test Plan:
- Reset, then a toggle at t0, sclk toggle 10 cycles later, out toggle 4 cycles after sclk_ev -> exp_pulse once; out_cnt=1, err_cnt=0, xor_state back to IDLE.
- a toggle, b toggle, sclk toggle, no out toggle -> exp_pulse never asserts; xor_state=3 before the clock, 0 after; err_cnt=0.
- a toggle twice then sclk -> state ONE_A throughout; exp_pulse=1. If out never toggles -> err_pulse WINDOW=8 cycles after exp_pulse; err_code=1, err_cnt=1.
- out toggle with the model idle -> err_code=2, err_cnt=1, out_cnt=0.
- Same-cycle events:
  - a_ev and sclk_ev coincide from IDLE -> no exp_pulse; xor_state=ONE_A afterwards.
  - a_ev and b_ev coincide from IDLE -> xor_state=BOTH.
- Two sclk pulses 3 cycles apart, each with a preceding a pulse, one out toggle -> one overrun (code 3) and out_cnt=1. Then force 300 spurious out toggles with CNT_W=8 -> err_cnt saturates at 255. Assert rst -> all outputs 0.

Source files
------------

// File: rtl/sfq_xor_monitor.sv
// Receive-side checker for toggle-encoded SFQ pulses around a clocked XOR cell.
// Decodes a/b/sclk/out toggles into one-cycle events, runs the clocked-XOR model,
// predicts output pulses and checks the DUT's out toggles against a window.
module sfq_xor_monitor #(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_tgl,
  input  logic             b_tgl,
  input  logic             sclk_tgl,
  input  logic             out_tgl,
  output logic             exp_pulse,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [1:0]       xor_state,
  output logic [CNT_W-1:0] out_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Model states; ONE_A/ONE_B/BOTH are chosen so a data event is a bitwise OR
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ONE_A = 2'd1;
  localparam logic [1:0] ONE_B = 2'd2;
  localparam logic [1:0] BOTH  = 2'd3;

  localparam logic [1:0] ERR_MISS = 2'd1;
  localparam logic [1:0] ERR_SPUR = 2'd2;
  localparam logic [1:0] ERR_OVR  = 2'd3;

  localparam logic [7:0]       WIN_LOAD = 8'(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Bit order: 0 a, 1 b, 2 sclk, 3 out
  logic [3:0] tgl_in;
  logic [3:0] sync1_q, sync2_q, hist_q;
  logic [3:0] ev;
  logic [1:0] mask_q;
  logic       a_ev, b_ev, sclk_ev, out_ev;

  logic [1:0]       state_q, state_d;
  logic             pend_q, pend_d;
  logic [7:0]       win_q, win_d;
  logic             exp_q, exp_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             match, miss, spur, ovr, expected;

  assign tgl_in = {out_tgl, sclk_tgl, b_tgl, a_tgl};

  // Two-flop synchroniser, history flop and post-reset settle mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      mask_q  <= 2'd3;
    end else begin
      sync1_q <= tgl_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      if (mask_q != 2'd0) mask_q <= mask_q - 2'd1;
    end
  end

  // Edge detect in both directions; suppressed while the synchroniser settles
  always_comb begin
    ev      = (sync2_q ^ hist_q) & {4{mask_q == 2'd0}};
    a_ev    = ev[0];
    b_ev    = ev[1];
    sclk_ev = ev[2];
    out_ev  = ev[3];
  end

  // Next state: match/window first, then sclk evaluation, then data events
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    win_d    = win_q;
    exp_d    = 1'b0;
    match    = 1'b0;
    miss     = 1'b0;
    spur     = 1'b0;
    ovr      = 1'b0;
    expected = 1'b0;

    if (pend_q) begin
      if (out_ev) begin
        match  = 1'b1;
        pend_d = 1'b0;
      end else if (win_q == 8'd1) begin
        miss   = 1'b1;
        pend_d = 1'b0;
      end else begin
        win_d = win_q - 8'd1;
      end
    end else if (out_ev) begin
      spur = 1'b1;
    end

    if (sclk_ev) begin
      expected = (state_q == ONE_A) || (state_q == ONE_B);
      state_d  = IDLE;
      // A still-open expectation at the next clock is an overrun either way
      if (pend_d) ovr = 1'b1;
      if (expected) begin
        exp_d  = 1'b1;
        pend_d = 1'b1;
        win_d  = WIN_LOAD;
      end else begin
        pend_d = 1'b0;
      end
    end

    state_d = state_d | {b_ev, a_ev};

    err_d = ovr | miss | spur;
    if (ovr)       code_d = ERR_OVR;
    else if (miss) code_d = ERR_MISS;
    else if (spur) code_d = ERR_SPUR;
    else           code_d = code_q;

    out_cnt_d = (match && out_cnt_q != CNT_MAX) ? out_cnt_q + 1'b1 : out_cnt_q;
    err_cnt_d = (err_d && err_cnt_q != CNT_MAX) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  // Model, pending window, strobes and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      win_q     <= '0;
      exp_q     <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      out_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      win_q     <= win_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      code_q    <= code_d;
      out_cnt_q <= out_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign exp_pulse = exp_q;
  assign err_pulse = err_q;
  assign err_code  = code_q;
  assign xor_state = state_q;
  assign out_cnt   = out_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
